// File: rtl/pipeline_hazard_ctrl_if.sv
// rtl/pipeline_hazard_ctrl_if.sv - hazard-detect inputs and stage-register controls (perf ports under HAZARD_PERF_CNT_EN)
interface pipeline_hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic [4:0] idex_rd;
    logic       idex_memread;
    logic       exmem_mem_access;
    logic       exmem_branch_taken;
    logic       dmem_ready;

    logic       pc_write;
    logic       ifid_write;
    logic       ifid_flush;
    logic       idex_flush;
    logic       exmem_write;
    logic       exmem_flush;
    logic       memwb_flush;
    logic       hazard_err;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    // pipeline side: supplies hazard information, consumes controls
    modport master (
        output id_rs1, id_rs2, idex_rd, idex_memread,
               exmem_mem_access, exmem_branch_taken, dmem_ready,
        input  pc_write, ifid_write, ifid_flush, idex_flush,
               exmem_write, exmem_flush, memwb_flush, hazard_err,
               stall_cnt, flush_cnt
    );

    // controller side
    modport slave (
        input  id_rs1, id_rs2, idex_rd, idex_memread,
               exmem_mem_access, exmem_branch_taken, dmem_ready,
        output pc_write, ifid_write, ifid_flush, idex_flush,
               exmem_write, exmem_flush, memwb_flush, hazard_err,
               stall_cnt, flush_cnt
    );
`else
    logic unused_cnt_w;
    assign unused_cnt_w = 1'(CNT_W);

    // pipeline side: supplies hazard information, consumes controls
    modport master (
        output id_rs1, id_rs2, idex_rd, idex_memread,
               exmem_mem_access, exmem_branch_taken, dmem_ready,
        input  pc_write, ifid_write, ifid_flush, idex_flush,
               exmem_write, exmem_flush, memwb_flush, hazard_err
    );

    // controller side
    modport slave (
        input  id_rs1, id_rs2, idex_rd, idex_memread,
               exmem_mem_access, exmem_branch_taken, dmem_ready,
        output pc_write, ifid_write, ifid_flush, idex_flush,
               exmem_write, exmem_flush, memwb_flush, hazard_err
    );
`endif
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush sequencer for the 5-stage pipeline (optional perf counters: HAZARD_PERF_CNT_EN)
module pipeline_hazard_ctrl #(
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    pipeline_hazard_ctrl_if.slave  hz
);
    localparam int WCW = $clog2(MAX_WAIT + 1);
    localparam logic [WCW-1:0] MAX_CNT = WCW'(MAX_WAIT);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } state_t;

    state_t         state;
    logic [WCW-1:0] wait_cnt;
    logic [WCW-1:0] next_cnt;
    logic           hazard_err_q;

    logic mem_wait;
    logic load_use;
    logic pc_write_c, ifid_write_c, ifid_flush_c, idex_flush_c;
    logic exmem_write_c, exmem_flush_c, memwb_flush_c;
    logic branch_flush_c;

    assign mem_wait = hz.exmem_mem_access & ~hz.dmem_ready;
    assign load_use = hz.idex_memread && (hz.idex_rd != 5'd0) &&
                      ((hz.idex_rd == hz.id_rs1) || (hz.idex_rd == hz.id_rs2));
    assign next_cnt = WCW'(wait_cnt + 1'b1);

    // Mealy control decode: reset/ERR > memory wait > branch flush > load-use
    always_comb begin
        pc_write_c     = 1'b1;
        ifid_write_c   = 1'b1;
        ifid_flush_c   = 1'b0;
        idex_flush_c   = 1'b0;
        exmem_write_c  = 1'b1;
        exmem_flush_c  = 1'b0;
        memwb_flush_c  = 1'b0;
        branch_flush_c = 1'b0;
        if (reset || state == ERR) begin
            pc_write_c    = 1'b0;
            ifid_write_c  = 1'b0;
            exmem_write_c = 1'b0;
            ifid_flush_c  = 1'b1;
            idex_flush_c  = 1'b1;
            exmem_flush_c = 1'b1;
            memwb_flush_c = 1'b1;
        end else if (mem_wait) begin
            // freeze everything up to EX/MEM; a deferred branch stays latched in EX/MEM
            pc_write_c    = 1'b0;
            ifid_write_c  = 1'b0;
            exmem_write_c = 1'b0;
            memwb_flush_c = 1'b1;
        end else if (hz.exmem_branch_taken) begin
            // squashes the load-use consumer too, so no stall is needed
            ifid_flush_c   = 1'b1;
            idex_flush_c   = 1'b1;
            exmem_flush_c  = 1'b1;
            branch_flush_c = 1'b1;
        end else if (load_use) begin
            pc_write_c   = 1'b0;
            ifid_write_c = 1'b0;
            idex_flush_c = 1'b1;
        end
    end

    assign hz.pc_write    = pc_write_c;
    assign hz.ifid_write  = ifid_write_c;
    assign hz.ifid_flush  = ifid_flush_c;
    assign hz.idex_flush  = idex_flush_c;
    assign hz.exmem_write = exmem_write_c;
    assign hz.exmem_flush = exmem_flush_c;
    assign hz.memwb_flush = memwb_flush_c;
    assign hz.hazard_err  = hazard_err_q;

    // state, watchdog counter and sticky error
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= RUN;
            wait_cnt     <= '0;
            hazard_err_q <= 1'b0;
        end else begin
            case (state)
                RUN, MEM_WAIT: begin
                    if (mem_wait) begin
                        wait_cnt <= next_cnt;
                        if (next_cnt == MAX_CNT) begin
                            state        <= ERR;
                            hazard_err_q <= 1'b1;
                        end else begin
                            state <= MEM_WAIT;
                        end
                    end else begin
                        state    <= RUN;
                        wait_cnt <= '0;
                    end
                end
                default: begin
                    state <= ERR;
                end
            endcase
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    // saturating stall/flush counters, frozen once in ERR
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else if (state != ERR) begin
            if (!pc_write_c && stall_cnt_q != {CNT_W{1'b1}})
                stall_cnt_q <= stall_cnt_q + 1'b1;
            if (branch_flush_c && flush_cnt_q != {CNT_W{1'b1}})
                flush_cnt_q <= flush_cnt_q + 1'b1;
        end
    end

    assign hz.stall_cnt = stall_cnt_q;
    assign hz.flush_cnt = flush_cnt_q;
`else
    logic unused_cnt_w;
    assign unused_cnt_w = 1'(CNT_W);
`endif
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - directed self-checking bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;
    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_pass   = 0;

    // control bundle: {pc_write, ifid_write, ifid_flush, idex_flush, exmem_write, exmem_flush, memwb_flush}
    localparam logic [6:0] C_RUN = 7'b1100100;
    localparam logic [6:0] C_RST = 7'b0011011;
    localparam logic [6:0] C_MW  = 7'b0000001;
    localparam logic [6:0] C_BR  = 7'b1111110;
    localparam logic [6:0] C_LU  = 7'b0001100;

    pipeline_hazard_ctrl_if #(.CNT_W(32)) hif ();

    pipeline_hazard_ctrl #(.MAX_WAIT(4), .CNT_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hif.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [6:0] ctl();
        return {hif.pc_write, hif.ifid_write, hif.ifid_flush, hif.idex_flush,
                hif.exmem_write, hif.exmem_flush, hif.memwb_flush};
    endfunction

    task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic mr, input logic ma, input logic br, input logic rdy);
        hif.id_rs1             = rs1;
        hif.id_rs2             = rs2;
        hif.idex_rd            = rd;
        hif.idex_memread       = mr;
        hif.exmem_mem_access   = ma;
        hif.exmem_branch_taken = br;
        hif.dmem_ready         = rdy;
    endtask

    // inputs applied 1 time unit after posedge, outputs checked 2 units later
    task automatic cycle_check(input string tag, input logic [6:0] exp_ctl, input logic exp_err);
        #2;
        check({tag, "_ctl"}, 32'(ctl()), 32'(exp_ctl));
        check({tag, "_err"}, 32'(hif.hazard_err), 32'(exp_err));
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        #1;
        cycle_check("reset", C_RST, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        cycle_check("idle", C_RUN, 1'b0);

        // load-use via rs2, then via rs1, then rd=0 never stalls
        drive(5'd1, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1);
        cycle_check("lu_rs2", C_LU, 1'b0);
        drive(5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        cycle_check("lu_after", C_RUN, 1'b0);
        drive(5'd7, 5'd3, 5'd7, 1'b1, 1'b0, 1'b0, 1'b1);
        cycle_check("lu_rs1", C_LU, 1'b0);
        drive(5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        cycle_check("lu_rd0", C_RUN, 1'b0);
        drive(5'd5, 5'd6, 5'd7, 1'b1, 1'b0, 1'b0, 1'b1);
        cycle_check("lu_nomatch", C_RUN, 1'b0);

        // zero-stall access, then a 3-cycle memory wait
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        cycle_check("mem_fast", C_RUN, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
            cycle_check($sformatf("mw%0d", i + 1), C_MW, 1'b0);
        end
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        cycle_check("mw_release", C_RUN, 1'b0);
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        cycle_check("mw_after", C_RUN, 1'b0);

        // branch overrides a simultaneous load-use match
        drive(5'd4, 5'd9, 5'd4, 1'b1, 1'b0, 1'b1, 1'b1);
        cycle_check("br_lu", C_BR, 1'b0);

        // branch deferred across a 2-cycle wait, flushes on the release cycle
        for (int i = 0; i < 2; i++) begin
            drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
            cycle_check($sformatf("brw%0d", i + 1), C_MW, 1'b0);
        end
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1);
        cycle_check("brw_release", C_BR, 1'b0);
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        cycle_check("brw_after", C_RUN, 1'b0);

`ifdef HAZARD_PERF_CNT_EN
        // 2 load-use + 3 wait + 2 wait stalls; 2 branch flushes
        check("stall_cnt", hif.stall_cnt, 32'd7);
        check("flush_cnt", hif.flush_cnt, 32'd2);
`endif

        // watchdog: 4 wait cycles stall, ERR from cycle 5, ready ignored afterwards
        for (int i = 0; i < 4; i++) begin
            drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
            cycle_check($sformatf("wd%0d", i + 1), C_MW, 1'b0);
        end
        cycle_check("wd5_err", C_RST, 1'b1);
        drive(5'd3, 5'd3, 5'd3, 1'b1, 1'b1, 1'b1, 1'b1);
        cycle_check("err_ready", C_RST, 1'b1);
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        cycle_check("err_sticky", C_RST, 1'b1);

`ifdef HAZARD_PERF_CNT_EN
        check("stall_cnt_err", hif.stall_cnt, 32'd11);
        check("flush_cnt_err", hif.flush_cnt, 32'd2);
`endif

        // asynchronous reset mid-ERR clears before the next clock edge
        #3;
        reset = 1'b1;
        #1;
        check("async_err", 32'(hif.hazard_err), 32'd0);
        check("async_ctl", 32'(ctl()), 32'(C_RST));
`ifdef HAZARD_PERF_CNT_EN
        check("async_stall_cnt", hif.stall_cnt, 32'd0);
`endif
        @(posedge clk);
        #1;
        reset = 1'b0;
        cycle_check("post_reset", C_RUN, 1'b0);
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle_check("post_reset_mw", C_MW, 1'b0);
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        cycle_check("post_reset_run", C_RUN, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
